btn_debounce_in: RTL and testbench
==================================

// Module: btn_debounce_in
// PURPOSE
//  Input-side counterpart of the LED indicator cell: reads a raw push-button/switch pin,
//  synchronises it, debounces it and emits a clean level, one-cycle press/release pulses
//  and a saturating press counter. Sits at board edge between the button footprint and core logic.
//  All state lives in discrete DFFs; debounce and freeze muxing in discrete gates/muxes.
// PARAMETERS
//  SYNC_STAGES     2   synchroniser depth on btn_i (>=2)
//  DEBOUNCE_CYCLES 10  consecutive stable samples required beyond the first (>=1)
//  ACTIVE_LOW      1   1: pin low = pressed (pull-up button); 0: pin high = pressed
//  CNT_WIDTH       4   width of press_cnt_o
// PORTS
//  clk_i        in   1          single clock
//  rst_i        in   1          asynchronous reset, active-high
//  dis_i        in   1          freeze: hold debounce state, suppress pulses
//  btn_i        in   1          raw asynchronous button pin
//  clr_cnt_i    in   1          synchronous clear of press_cnt_o
//  level_o      out  1          debounced pressed level (1 = pressed)
//  press_o      out  1          one-cycle pulse on debounced press
//  release_o    out  1          one-cycle pulse on debounced release
//  press_cnt_o  out  CNT_WIDTH  saturating count of press_o pulses
// BEHAVIOUR
//  Reset (async, immediate): sync chain = inactive pin level (ACTIVE_LOW ? 1 : 0); FSM = STABLE_LO;
//   debounce cnt = 0; level_o = 0; press_o = release_o = 0; press_cnt_o = 0. Reset mid-debounce discards it.
//  s = last sync stage XOR ACTIVE_LOW (1 = pressed). Sync chain always shifts, even when dis_i = 1.
//  Debounce cnt width = $clog2(DEBOUNCE_CYCLES+1). FSM (evaluated only when dis_i = 0):
//   STABLE_LO: s=1 -> CHECK_HI, cnt<=1; else stay.
//   CHECK_HI : s=0 -> STABLE_LO, cnt<=0 (bounce, no pulse); cnt==DEBOUNCE_CYCLES -> STABLE_HI, cnt<=0;
//              else cnt<=cnt+1.
//   STABLE_HI: s=0 -> CHECK_LO, cnt<=1; else stay.
//   CHECK_LO : symmetric to CHECK_HI (s=1 -> STABLE_HI; terminal count -> STABLE_LO).
//  level_o = 1 in STABLE_HI and CHECK_LO; 0 in STABLE_LO and CHECK_HI (registered, glitch-free).
//  press_o high exactly the first cycle in STABLE_HI after CHECK_HI; release_o likewise for STABLE_LO.
//   Never both high; never high two cycles in a row.
//  Latency: pin held pressed from the edge that first samples it -> level_o/press_o high after exactly
//   SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges. Same for release. Any opposite sample restarts the count.
//  dis_i = 1: FSM, cnt, level_o frozen; press_o/release_o forced 0 the same cycle; a pulse due on that
//   edge is lost. Resumes on dis_i = 0 using current s.
//  press_cnt_o: +1 on each press_o; saturates at all-ones (no wrap). clr_cnt_i = 1 -> 0 next edge;
//   clear beats a simultaneous press (result 0). clr_cnt_i honoured while dis_i = 1.
// STRUCTURE
//  Package btn_pkg: typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} btn_state_e.
//  Sub-module btn_sync (SYNC_STAGES, RESET_VAL): DFF shift chain with async reset to RESET_VAL.
//  Top holds FSM, debounce counter, pulse regs, press counter.
// TESTING (defaults: SYNC_STAGES=2, DEBOUNCE_CYCLES=10, ACTIVE_LOW=1, CNT_WIDTH=4)
//  Reset: btn_i=1, rst_i pulsed mid-cycle -> all outputs 0 immediately, no pulse after release.
//  Clean press: btn_i 1->0 held 20 cycles -> level_o=1, press_o single pulse at edge 13; cnt_o=1;
//   release -> release_o at edge 13 after release, level_o=0.
//  Bounce: btn_i low 5 cycles, high 1, low 20 -> no early pulse; press_o 13 edges after last falling edge.
//  Freeze: dis_i=1 during debounce 8 cycles then 0 -> level_o held; press_o delayed 8 cycles; no pulse while frozen.
//  Saturation/clear: 17 clean presses -> press_cnt_o=15; clr_cnt_i with coincident press_o -> 0.
//  Polarity: ACTIVE_LOW=0, btn_i 0->1 held -> press_o after 13 edges; reset sync value 0 gives no spurious press.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types for the button debounce input cell.
package btn_pkg;

    // Debounce FSM states: two stable levels, each with a qualifying state toward the other.
    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } btn_state_e;

    // Width needed to hold a count of 0..n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-stage flip-flop synchroniser for an asynchronous pin; resets to a chosen idle level.
module btn_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw pin through the chain every cycle; reset fills it with the idle level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce_in.sv
// Button input cell: synchronise, debounce, and report level, edge pulses and a press count.
module btn_debounce_in
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_WIDTH       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dis_i,
    input  logic                 btn_i,
    input  logic                 clr_cnt_i,
    output logic                 level_o,
    output logic                 press_o,
    output logic                 release_o,
    output logic [CNT_WIDTH-1:0] press_cnt_o
);

    localparam int unsigned    DW       = count_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  TERM_CNT = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  ONE_CNT  = DW'(1);
    localparam logic           IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic           sync_q;
    logic           s;
    btn_state_e     state_q, state_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic [CNT_WIDTH-1:0] press_cnt_q;

    btn_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (IDLE_PIN)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_i),
        .q_o   (sync_q)
    );

    // Normalise the synchronised pin so that 1 always means pressed.
    assign s = sync_q ^ ACTIVE_LOW;

    // FSM, debounce counter, level and pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state logic; with dis_i high everything holds and no pulse is generated.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (!dis_i) begin
            unique case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_d = CHECK_HI;
                        cnt_d   = ONE_CNT;
                    end
                end
                CHECK_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == TERM_CNT) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_d = CHECK_LO;
                        cnt_d   = ONE_CNT;
                    end
                end
                CHECK_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == TERM_CNT) begin
                        state_d   = STABLE_LO;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    // Saturating press counter; clear has priority and works even while frozen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            press_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            press_cnt_q <= '0;
        end else if (press_o && (press_cnt_q != '1)) begin
            press_cnt_q <= press_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Freeze masks a pending pulse in the same cycle, so the counter never sees it either.
    assign level_o     = level_q;
    assign press_o     = press_q & ~dis_i;
    assign release_o   = release_q & ~dis_i;
    assign press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce_in.sv
// Directed self-checking bench: active-low DUT (a) and active-high DUT (b).
module tb_btn_debounce_in;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       dis_i;
    logic       clr_cnt_i;
    logic       btn_a, btn_b;
    logic       level_a, press_a, release_a;
    logic       level_b, press_b, release_b;
    logic [3:0] cnt_a, cnt_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    btn_debounce_in #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (10),
        .ACTIVE_LOW      (1'b1),
        .CNT_WIDTH       (4)
    ) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dis_i       (dis_i),
        .btn_i       (btn_a),
        .clr_cnt_i   (clr_cnt_i),
        .level_o     (level_a),
        .press_o     (press_a),
        .release_o   (release_a),
        .press_cnt_o (cnt_a)
    );

    btn_debounce_in #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (10),
        .ACTIVE_LOW      (1'b0),
        .CNT_WIDTH       (4)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dis_i       (dis_i),
        .btn_i       (btn_b),
        .clr_cnt_i   (clr_cnt_i),
        .level_o     (level_b),
        .press_o     (press_b),
        .release_o   (release_b),
        .press_cnt_o (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n edges on DUT sel (0=a, 1=b); press/release expected exactly on the given edge (0 = never).
    task automatic run(input int unsigned sel, input int unsigned n, input int unsigned press_at,
                       input int unsigned rel_at, input logic lvl0, input string tag);
        logic lvl;
        for (int unsigned k = 1; k <= n; k++) begin
            step();
            lvl = lvl0;
            if (press_at != 0 && k >= press_at) lvl = 1'b1;
            if (rel_at != 0 && k >= rel_at) lvl = 1'b0;
            check($sformatf("%s_press_e%0d", tag, k), (sel == 0) ? press_a : press_b,
                  32'(k == press_at));
            check($sformatf("%s_release_e%0d", tag, k), (sel == 0) ? release_a : release_b,
                  32'(k == rel_at));
            check($sformatf("%s_level_e%0d", tag, k), (sel == 0) ? level_a : level_b, 32'(lvl));
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        dis_i     = 1'b0;
        clr_cnt_i = 1'b0;
        btn_a     = 1'b1;
        btn_b     = 1'b0;
        #2;
        check("rst_level_a", level_a, 0);
        check("rst_press_a", press_a, 0);
        check("rst_release_a", release_a, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_level_b", level_b, 0);
        check("rst_cnt_b", cnt_b, 0);
        step();
        step();
        rst_i = 1'b0;
        run(0, 5, 0, 0, 1'b0, "idle_a");
        run(1, 15, 0, 0, 1'b0, "idle_b");

        // Clean press and release.
        btn_a = 1'b0;
        run(0, 20, 13, 0, 1'b0, "press");
        check("press_cnt1", cnt_a, 1);
        btn_a = 1'b1;
        run(0, 20, 0, 13, 1'b1, "release");
        check("release_cnt1", cnt_a, 1);

        // Bounce: 5 low, 1 high, then held low.
        btn_a = 1'b0;
        run(0, 5, 0, 0, 1'b0, "bounce_pre");
        btn_a = 1'b1;
        run(0, 1, 0, 0, 1'b0, "bounce_glitch");
        btn_a = 1'b0;
        run(0, 20, 13, 0, 1'b0, "bounce");
        check("bounce_cnt2", cnt_a, 2);
        btn_a = 1'b1;
        run(0, 20, 0, 13, 1'b1, "bounce_rel");

        // Freeze for 8 edges in the middle of a debounce.
        btn_a = 1'b0;
        run(0, 5, 0, 0, 1'b0, "frz_pre");
        dis_i = 1'b1;
        run(0, 8, 0, 0, 1'b0, "frozen");
        dis_i = 1'b0;
        run(0, 12, 8, 0, 1'b0, "thaw");
        check("frz_cnt3", cnt_a, 3);
        btn_a = 1'b1;
        run(0, 20, 0, 13, 1'b1, "frz_rel");

        // Clear honoured while frozen.
        dis_i     = 1'b1;
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        dis_i     = 1'b0;
        check("clr_frozen", cnt_a, 0);

        // Saturation after 17 presses.
        for (int unsigned p = 0; p < 17; p++) begin
            btn_a = 1'b0;
            run(0, 20, 13, 0, 1'b0, $sformatf("sat%0d", p));
            btn_a = 1'b1;
            run(0, 20, 0, 13, 1'b1, $sformatf("sat%0d_rel", p));
        end
        check("sat_cnt15", cnt_a, 15);

        // Clear coinciding with a press pulse.
        btn_a = 1'b0;
        run(0, 13, 13, 0, 1'b0, "clrp");
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        check("clrp_cnt0", cnt_a, 0);
        check("clrp_pulse_gone", press_a, 0);
        btn_a = 1'b1;
        run(0, 20, 0, 13, 1'b1, "clrp_rel");
        check("clrp_cnt_after", cnt_a, 0);

        // Asynchronous reset mid-release debounce with the pin idle.
        btn_a = 1'b0;
        run(0, 20, 13, 0, 1'b0, "prerst");
        check("prerst_cnt1", cnt_a, 1);
        btn_a = 1'b1;
        run(0, 6, 0, 0, 1'b1, "rst_mid");
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_level", level_a, 0);
        check("arst_cnt", cnt_a, 0);
        check("arst_press", press_a, 0);
        check("arst_release", release_a, 0);
        #2;
        rst_i = 1'b0;
        run(0, 20, 0, 0, 1'b0, "post_rst");

        // Reset during a press debounce restarts the count.
        btn_a = 1'b0;
        run(0, 6, 0, 0, 1'b0, "rst2_pre");
        #3;
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        run(0, 20, 13, 0, 1'b0, "rst_restart");
        btn_a = 1'b1;
        run(0, 20, 0, 13, 1'b1, "rst_restart_rel");

        // Active-high polarity.
        btn_b = 1'b1;
        run(1, 20, 13, 0, 1'b0, "b_press");
        check("b_cnt1", cnt_b, 1);
        btn_b = 1'b0;
        run(1, 20, 0, 13, 1'b1, "b_rel");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
